clock_time_controller: RTL and testbench
========================================

// Module: clock_time_controller
// PURPOSE
//   Time-of-day sequencer for the six-digit HH:MM:SS seven-segment display.
//   - Divides clk into a 1 Hz tick and advances the binary ss/mm/hh counters
//     that feed the binary-to-7-seg display block.
//   - Runs a button-driven set-mode FSM so the user can edit hours, minutes and seconds.
// PARAMETERS
//   TICK_DIV  50_000_000  clk cycles per 1 s tick (>=2; bench uses 4)
//   HOUR_MAX  24          hour modulus (24 or 12); hh counts 0..HOUR_MAX-1
// PORTS
//   clk        in   1  single system clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   mode_btn   in   1  debounced, synchronous 1-cycle pulse: advance edit mode
//   inc_btn    in   1  debounced, synchronous 1-cycle pulse: increment selected field
//   ss         out  7  seconds, binary 0..59
//   mm         out  6  minutes, binary 0..59
//   hh         out  5  hours, binary 0..HOUR_MAX-1
//   edit_sel   out  2  0=run, 1=hh, 2=mm, 3=ss; display blinks the selected field
//   sec_tick   out  1  1-cycle pulse in the cycle ss advances in RUN
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - ss=mm=hh=0, state=RUN, edit_sel=0, sec_tick=0, prescaler=0.
//   Prescaler:
//     - Counts 0..TICK_DIV-1 only while state=RUN; tick when count==TICK_DIV-1, then wraps to 0.
//     - Held at 0 in every SET state.
//   RUN, on tick, all updates registered on the same edge:
//     - ss+1.
//     - ss 59->0 carries to mm+1; mm 59->0 carries to hh+1; hh HOUR_MAX-1 -> 0.
//     - sec_tick=1 for that one cycle.
//   FSM: RUN -> SET_HH -> SET_MM -> SET_SS -> RUN, one step per mode_btn pulse.
//     - edit_sel is registered and equals the state encoding.
//     - Leaving SET_SS restarts the prescaler at 0: first tick comes TICK_DIV cycles later.
//   SET_x, inc_btn:
//     - Increments only the selected field, modulo its range (59->0, HOUR_MAX-1->0).
//     - No carry into other fields; time is frozen.
//   inc_btn in RUN: ignored.
//   mode_btn and inc_btn in the same cycle: mode wins, inc is dropped.
//   mode_btn in the cycle a RUN tick is due: the tick is applied, then state moves to SET_HH.
//   Arithmetic:
//     - Fields are stored binary; the display does the decimal split.
//     - Upper bits beyond the legal range are never set (ss bit6 always 0).
//   Reset mid-edit: returns to RUN at 00:00:00 immediately, asynchronously.
// CONFIGURATION
//   Macro: CLOCK_CTRL_ALARM_EN
//   Defined:
//     - FSM gains SET_AH and SET_AM after SET_SS (order: ...SET_SS -> SET_AH -> SET_AM -> RUN).
//     - edit_sel widens to 3 bits (4=alarm hh, 5=alarm mm).
//     - Adds registers alarm_hh[4:0] and alarm_mm[5:0], both reset to 0.
//     - Adds input alarm_arm (level) and output alarm_out.
//     - alarm_out=1 while alarm_arm && state==RUN && hh==alarm_hh && mm==alarm_mm,
//       i.e. for the whole matching minute.
//   Undefined:
//     - No alarm ports or registers; edit_sel is 2 bits; 4-state FSM as above.
// STRUCTURE
//   Package clock_ctrl_pkg:
//     - State enum (RUN, SET_HH, SET_MM, SET_SS, SET_AH, SET_AM).
//     - Constants SEC_MAX=59, MIN_MAX=59.
//     - Field widths SS_W=7, MM_W=6, HH_W=5.
//   Sub-module tick_prescaler:
//     - Parameter TICK_DIV; inputs clk, rst_n, run; output tick.
//   Top instantiates it and holds the FSM plus the field counters.
// TESTING (TICK_DIV=4, HOUR_MAX=24)
//   1. Release reset, idle 12 cycles -> ss=3, mm=0, hh=0; exactly 3 sec_tick pulses, 4 cycles apart.
//   2. Preload 23:59:59 via set mode, return to RUN, wait 4 cycles -> 00:00:00 on one edge.
//   3. mode_btn x1, inc_btn x25 -> edit_sel=1, hh=1 (wraps at 24); ss and mm unchanged; no sec_tick.
//   4. In SET_MM with mm=59, mode_btn and inc_btn in the same cycle -> edit_sel=3, mm stays 59.
//   5. Assert rst_n=0 mid-cycle while in SET_SS with ss=30 -> outputs 0 and edit_sel=0 before the next clk edge.
//   6. (ALARM_EN) alarm 00:01, alarm_arm=1, run from 00:00:00 -> alarm_out rises with mm=1
//      and falls when mm=2 (240 cycles later).

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clock_ctrl_pkg
//   Shared types and constants for the HH:MM:SS time-of-day controller.
//   - state_e : set-mode FSM encoding; edit_sel carries the low SEL_W bits
//               of this encoding straight to the display.
//   - SS_W/MM_W/HH_W : binary field widths.
//   - SEC_MAX/MIN_MAX : last legal value of the seconds/minutes fields.
//   - SEL_W : edit_sel width (3 when CLOCK_CTRL_ALARM_EN is defined, else 2).
//   Configuration macro: CLOCK_CTRL_ALARM_EN
// ---------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_HH = 3'd1,
        SET_MM = 3'd2,
        SET_SS = 3'd3,
        SET_AH = 3'd4,
        SET_AM = 3'd5
    } state_e;

    localparam int SS_W = 7;
    localparam int MM_W = 6;
    localparam int HH_W = 5;

    localparam logic [SS_W-1:0] SEC_MAX = 7'd59;
    localparam logic [MM_W-1:0] MIN_MAX = 6'd59;

`ifdef CLOCK_CTRL_ALARM_EN
    localparam int SEL_W = 3;
`else
    localparam int SEL_W = 2;
`endif

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//   Divides clk down to a one-cycle tick every TICK_DIV cycles while run=1.
//   While run=0 the count is held at 0, so the first tick after run rises
//   arrives exactly TICK_DIV cycles later.
//   Ports:
//     clk   in  system clock, rising edge
//     rst_n in  asynchronous active-low reset (count -> 0)
//     run   in  enable counting; 0 forces the count to 0
//     tick  out combinational, high in the last cycle of each period
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = run && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!run || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clock_time_controller.sv
// ---------------------------------------------------------------------------
// clock_time_controller
//   Time-of-day sequencer: advances binary ss/mm/hh once per second in RUN
//   and runs a button-driven set-mode FSM for editing each field.
//   Ports:
//     clk       in   system clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     mode_btn  in   1-cycle pulse, step to the next edit mode (wins over inc)
//     inc_btn   in   1-cycle pulse, increment the selected field (SET only)
//     ss/mm/hh  out  binary time fields
//     edit_sel  out  current FSM state encoding (0=run, 1=hh, 2=mm, 3=ss,
//                    4=alarm hh, 5=alarm mm)
//     sec_tick  out  registered pulse in the cycle ss has just advanced
//     alarm_arm in   (alarm build) level, enables alarm_out
//     alarm_out out  (alarm build) high for the whole matching minute in RUN
//   Configuration macro: CLOCK_CTRL_ALARM_EN adds the alarm fields, two extra
//   FSM states, and the alarm ports.
// ---------------------------------------------------------------------------
module clock_time_controller
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOUR_MAX = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_btn,
    input  logic             inc_btn,
`ifdef CLOCK_CTRL_ALARM_EN
    input  logic             alarm_arm,
    output logic             alarm_out,
`endif
    output logic [SS_W-1:0]  ss,
    output logic [MM_W-1:0]  mm,
    output logic [HH_W-1:0]  hh,
    output logic [SEL_W-1:0] edit_sel,
    output logic             sec_tick
);

    localparam logic [HH_W-1:0] HOUR_LAST = HH_W'(HOUR_MAX - 1);

    state_e          state_q, state_d;
    logic [SS_W-1:0] ss_q, ss_d, ss_inc;
    logic [MM_W-1:0] mm_q, mm_d, mm_inc;
    logic [HH_W-1:0] hh_q, hh_d, hh_inc;
    logic            sec_tick_q, sec_tick_d;
    logic            tick;

`ifdef CLOCK_CTRL_ALARM_EN
    logic [HH_W-1:0] alarm_hh_q, alarm_hh_d, alarm_hh_inc;
    logic [MM_W-1:0] alarm_mm_q, alarm_mm_d, alarm_mm_inc;
`endif

    // Prescaler only runs in RUN; entering RUN from a SET state therefore
    // always starts a fresh full second.
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q == RUN),
        .tick  (tick)
    );

    // Wrapping increments shared by the RUN carry chain and the SET editors.
    assign ss_inc = (ss_q == SEC_MAX)   ? '0 : ss_q + SS_W'(1);
    assign mm_inc = (mm_q == MIN_MAX)   ? '0 : mm_q + MM_W'(1);
    assign hh_inc = (hh_q == HOUR_LAST) ? '0 : hh_q + HH_W'(1);

`ifdef CLOCK_CTRL_ALARM_EN
    assign alarm_hh_inc = (alarm_hh_q == HOUR_LAST) ? '0 : alarm_hh_q + HH_W'(1);
    assign alarm_mm_inc = (alarm_mm_q == MIN_MAX)   ? '0 : alarm_mm_q + MM_W'(1);
`endif

    // Next-state and field updates. tick is only ever high in RUN, so the
    // time advance and a simultaneous mode step can both take effect.
    always_comb begin
        state_d    = state_q;
        ss_d       = ss_q;
        mm_d       = mm_q;
        hh_d       = hh_q;
        sec_tick_d = 1'b0;
`ifdef CLOCK_CTRL_ALARM_EN
        alarm_hh_d = alarm_hh_q;
        alarm_mm_d = alarm_mm_q;
`endif

        if (tick) begin
            sec_tick_d = 1'b1;
            ss_d       = ss_inc;
            if (ss_q == SEC_MAX) begin
                mm_d = mm_inc;
                if (mm_q == MIN_MAX) begin
                    hh_d = hh_inc;
                end
            end
        end

        if (mode_btn) begin
            case (state_q)
                RUN:     state_d = SET_HH;
                SET_HH:  state_d = SET_MM;
                SET_MM:  state_d = SET_SS;
`ifdef CLOCK_CTRL_ALARM_EN
                SET_SS:  state_d = SET_AH;
`else
                SET_SS:  state_d = RUN;
`endif
                SET_AH:  state_d = SET_AM;
                SET_AM:  state_d = RUN;
                default: state_d = RUN;
            endcase
        end else if (inc_btn) begin
            // Editing touches one field only: no carries.
            case (state_q)
                SET_HH:  hh_d = hh_inc;
                SET_MM:  mm_d = mm_inc;
                SET_SS:  ss_d = ss_inc;
`ifdef CLOCK_CTRL_ALARM_EN
                SET_AH:  alarm_hh_d = alarm_hh_inc;
                SET_AM:  alarm_mm_d = alarm_mm_inc;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ss_q       <= '0;
            mm_q       <= '0;
            hh_q       <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_q       <= ss_d;
            mm_q       <= mm_d;
            hh_q       <= hh_d;
            sec_tick_q <= sec_tick_d;
        end
    end

`ifdef CLOCK_CTRL_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hh_q <= '0;
            alarm_mm_q <= '0;
        end else begin
            alarm_hh_q <= alarm_hh_d;
            alarm_mm_q <= alarm_mm_d;
        end
    end

    assign alarm_out = alarm_arm && (state_q == RUN) &&
                       (hh_q == alarm_hh_q) && (mm_q == alarm_mm_q);
`endif

    assign ss       = ss_q;
    assign mm       = mm_q;
    assign hh       = hh_q;
    assign edit_sel = state_q[SEL_W-1:0];
    assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_time_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_time_controller
//   Directed bench for clock_time_controller with TICK_DIV=4, HOUR_MAX=24.
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
//   The alarm scenario is built only when CLOCK_CTRL_ALARM_EN is defined.
// ---------------------------------------------------------------------------
module tb_clock_time_controller;

    localparam int TICK_DIV = 4;
    localparam int HOUR_MAX = 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic mode_btn = 1'b0;
    logic inc_btn  = 1'b0;
    logic [6:0] ss;
    logic [5:0] mm;
    logic [4:0] hh;
`ifdef CLOCK_CTRL_ALARM_EN
    logic [2:0] edit_sel;
    logic alarm_arm = 1'b0;
    logic alarm_out;
`else
    logic [1:0] edit_sel;
`endif
    logic sec_tick;

    clock_time_controller #(
        .TICK_DIV (TICK_DIV),
        .HOUR_MAX (HOUR_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
`ifdef CLOCK_CTRL_ALARM_EN
        .alarm_arm (alarm_arm),
        .alarm_out (alarm_out),
`endif
        .ss        (ss),
        .mm        (mm),
        .hh        (hh),
        .edit_sel  (edit_sel),
        .sec_tick  (sec_tick)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int ticks    = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int e_hh, input int e_mm, input int e_ss);
        check({tag, "_hh"}, 32'(hh), 32'(e_hh));
        check({tag, "_mm"}, 32'(mm), 32'(e_mm));
        check({tag, "_ss"}, 32'(ss), 32'(e_ss));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        if (sec_tick === 1'b1) ticks++;
    endtask

    task automatic pulse_mode();
        mode_btn = 1'b1;
        cycle();
        mode_btn = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc_btn = 1'b1;
            cycle();
        end
        inc_btn = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #12;
        check_time("reset", 0, 0, 0);
        check("reset_edit_sel", 32'(edit_sel), 0);
        check("reset_sec_tick", 32'(sec_tick), 0);

        // 1. Free run: ticks on edges 4, 8, 12 after release
        rst_n = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(8);
        exp_q.push_back(12);
        for (int c = 1; c <= 12; c++) begin
            cycle();
            if (sec_tick === 1'b1) begin
                if (exp_q.size() != 0) check("tick_cycle", 32'(c), exp_q.pop_front());
                else                   check("extra_tick_cycle", 32'(c), 0);
            end
        end
        check("missed_ticks", 32'(exp_q.size()), 0);
        check("run_ticks", 32'(ticks), 3);
        check_time("run12", 0, 0, 3);

        // 2. Preload 23:59:59 and roll over
        ticks = 0;
        pulse_mode();
        check("edit_hh", 32'(edit_sel), 1);
        pulse_inc(23);
        pulse_mode();
        check("edit_mm", 32'(edit_sel), 2);
        pulse_inc(59);
        pulse_mode();
        check("edit_ss", 32'(edit_sel), 3);
        pulse_inc(56);
        check_time("preload", 23, 59, 59);
        check("set_no_ticks", 32'(ticks), 0);
        pulse_mode();
        check("back_to_run", 32'(edit_sel), 0);
        for (int i = 0; i < 3; i++) cycle();
        check_time("pre_wrap", 23, 59, 59);
        check("pre_wrap_tick", 32'(sec_tick), 0);
        cycle();
        check_time("wrap", 0, 0, 0);
        check("wrap_tick", 32'(sec_tick), 1);

        // Mode pressed in the cycle a tick is due: tick applied, then SET_HH
        for (int i = 0; i < 3; i++) cycle();
        pulse_mode();
        check_time("mode_on_tick", 0, 0, 1);
        check("mode_on_tick_sel", 32'(edit_sel), 1);
        check("mode_on_tick_pulse", 32'(sec_tick), 1);

        // 3. 25 increments of hh wrap at 24 -> 1; time frozen
        ticks = 0;
        pulse_inc(25);
        check_time("hh_wrap", 1, 0, 1);
        check("hh_wrap_sel", 32'(edit_sel), 1);
        check("hh_wrap_ticks", 32'(ticks), 0);

        // 4. mode and inc together in SET_MM with mm=59: mode wins
        pulse_mode();
        pulse_inc(59);
        check("mm_59", 32'(mm), 59);
        mode_btn = 1'b1;
        inc_btn  = 1'b1;
        cycle();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        check("mode_wins_sel", 32'(edit_sel), 3);
        check("mode_wins_mm", 32'(mm), 59);
        // ss edit wraps without carrying into mm/hh
        pulse_inc(60);
        check_time("ss_wrap_nocarry", 1, 59, 1);
        pulse_inc(29);
        check_time("ss_30", 1, 59, 30);
        check("no_tick_in_set", 32'(ticks), 0);

        // 5. Asynchronous reset mid-cycle in SET_SS
        #3;
        rst_n = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst_sel", 32'(edit_sel), 0);
        check("async_rst_tick", 32'(sec_tick), 0);
        #10;
        rst_n = 1'b1;

        // inc_btn in RUN is ignored (two cycles, no tick due yet)
        inc_btn = 1'b1;
        cycle();
        cycle();
        inc_btn = 1'b0;
        check_time("inc_in_run", 0, 0, 0);
        check("inc_in_run_sel", 32'(edit_sel), 0);

`ifdef CLOCK_CTRL_ALARM_EN
        // 6. Alarm at 00:01
        begin
            int rise_c;
            int fall_c;
            rise_c = -1;
            fall_c = -1;
            #3;
            rst_n = 1'b0;
            #3;
            rst_n = 1'b1;
            for (int i = 0; i < 4; i++) pulse_mode();
            check("edit_ah", 32'(edit_sel), 4);
            pulse_mode();
            check("edit_am", 32'(edit_sel), 5);
            pulse_inc(1);
            alarm_arm = 1'b1;
            pulse_mode();
            check("alarm_run_sel", 32'(edit_sel), 0);
            check("alarm_low_at_start", 32'(alarm_out), 0);
            for (int c = 1; c <= 500; c++) begin
                cycle();
                if (alarm_out === 1'b1 && rise_c < 0) begin
                    rise_c = c;
                    check("alarm_rise_mm", 32'(mm), 1);
                end
                if (alarm_out !== 1'b1 && rise_c >= 0 && fall_c < 0) begin
                    fall_c = c;
                    check("alarm_fall_mm", 32'(mm), 2);
                end
            end
            check("alarm_rise_cycle", 32'(rise_c), 240);
            check("alarm_fall_cycle", 32'(fall_c), 480);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
